div_shift_sub: RTL

- Restoring shift-and-subtract unsigned divider; the inverse counterpart of the shift-and-add multiplier.
- Uses the same in_valid / stall / out_valid handshake.
- Latency is deliberately data-dependent (zero-remainder early exit), so it can be instantiated twice under the contract miter as a timing-leak target.
- Exposes current and next internal state so miter-side shadow predicates can observe it.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 28 ++
 rtl/div_shift_sub.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the shift-and-subtract divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_LOG = 2;
    localparam int unsigned DIV_WIDTH     = 1 << DIV_WIDTH_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] q;
        logic [DIV_WIDTH-1:0] r;
    } result_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             qbit
);

    logic [WIDTH:0] t;

    // Trial subtraction; the WIDTH-bit modular difference is exact because rem < dvs.
    always_comb begin
        t       = {rem, dvd_msb};
        qbit    = 1'b0;
        rem_out = t[WIDTH-1:0];
        if (t >= {1'b0, dvs}) begin
            qbit    = 1'b1;
            rem_out = t[WIDTH-1:0] - dvs;
        end
    end

endmodule

// File: rtl/div_shift_sub.sv
// Restoring shift-and-subtract unsigned divider with data-dependent latency
// (zero-remainder early exit) and exposed current/next internal state.
module div_shift_sub
    import div_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = DIV_WIDTH_LOG,
    parameter int unsigned WIDTH     = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] dvd_reg,
    output logic [WIDTH-1:0] rem_reg,
    output logic [WIDTH-1:0] dvd_next,
    output logic [WIDTH-1:0] rem_next,
    output logic             finish_next
);

    localparam int unsigned    CW      = WIDTH_LOG + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] dvs, dvs_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] q_d, r_d, dvd_d, rem_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_reg),
        .dvd_msb (dvd_reg[WIDTH-1]),
        .dvs     (dvs),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

    // Next-state logic, computed as if unstalled; stall only gates the register update.
    always_comb begin
        state_d = state;
        q_d     = q;
        r_d     = r;
        dvd_d   = dvd_reg;
        rem_d   = rem_reg;
        quo_d   = quo;
        dvs_d   = dvs;
        cnt_d   = cnt;
        shamt   = CNT_MAX - cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (b == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = a;
                    end else begin
                        state_d = RUN;
                        dvd_d   = a;
                        dvs_d   = b;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (cnt == CNT_MAX) begin
                    state_d = DONE;
                    q_d     = quo;
                    r_d     = rem_reg;
                end else if (dvd_reg == '0 && rem_reg == '0) begin
                    // Remaining quotient bits are all zero: left-align what we have.
                    state_d = DONE;
                    q_d     = quo << shamt;
                    r_d     = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = (quo << 1) | WIDTH'(step_qbit);
                    dvd_d = dvd_reg << 1;
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; async reset clears everything, stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            r       <= '0;
            dvd_reg <= '0;
            rem_reg <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
        end else if (!stall) begin
            state   <= state_d;
            q       <= q_d;
            r       <= r_d;
            dvd_reg <= dvd_d;
            rem_reg <= rem_d;
            quo     <= quo_d;
            dvs     <= dvs_d;
            cnt     <= cnt_d;
        end
    end

    // Status and pre-stall next-state observation ports.
    always_comb begin
        out_valid   = (state == DONE);
        busy        = (state != IDLE);
        dvd_next    = dvd_d;
        rem_next    = rem_d;
        finish_next = (state_d == DONE);
    end

endmodule
